// File: rtl/cfs_apb_pkg.sv
// Shared types and default widths for the CFS APB initiator.
package cfs_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } cfs_apb_master_state_t;

   typedef enum logic {
      CFS_APB_READ  = 1'b0,
      CFS_APB_WRITE = 1'b1
   } cfs_apb_dir_t;

   localparam int unsigned CFS_APB_MAX_ADDR_WIDTH = 16;
   localparam int unsigned CFS_APB_MAX_DATA_WIDTH = 32;

endpackage

// File: rtl/cfs_apb_timeout_cnt.sv
// Access-phase wait counter; expired_c flags the last allowed wait cycle.
module cfs_apb_timeout_cnt #(
   parameter int unsigned LIMIT     = 256,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic pclk,
   input  logic preset,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned TERM = (LIMIT > 0) ? LIMIT - 1 : 0;

   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge pclk) begin
      if (preset || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   // LIMIT of zero disables expiry entirely
   assign expired_c = (LIMIT != 0) && en && (cnt_q == CNT_WIDTH'(TERM));

endmodule

// File: rtl/cfs_apb_master.sv
// Converts one valid/ready request into a single APB transfer and returns a
// valid/ready response carrying read data, slave error and timeout status.
module cfs_apb_master
   import cfs_apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = CFS_APB_MAX_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = CFS_APB_MAX_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_slverr,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic                  psel,
   output logic                  penable,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam logic [1:0] S_IDLE   = 2'(IDLE);
   localparam logic [1:0] S_SETUP  = 2'(SETUP);
   localparam logic [1:0] S_ACCESS = 2'(ACCESS);
   localparam logic [1:0] S_RESP   = 2'(RESP);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_d, rsp_rdata_d;
   logic                  pwrite_d, psel_d, penable_d;
   logic                  rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
   logic                  cnt_clr, cnt_en, expired_c;

   assign req_ready = (state_q == S_IDLE) && !preset;
   assign cnt_en    = (state_q == S_ACCESS) && !pready;

   cfs_apb_timeout_cnt #(
      .LIMIT     (TIMEOUT_CYCLES),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_timeout_cnt (
      .pclk      (pclk),
      .preset    (preset),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .expired_c (expired_c)
   );

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q     <= S_IDLE;
         paddr       <= '0;
         pwdata      <= '0;
         pwrite      <= 1'b0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         paddr       <= paddr_d;
         pwdata      <= pwdata_d;
         pwrite      <= pwrite_d;
         psel        <= psel_d;
         penable     <= penable_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_slverr  <= rsp_slverr_d;
         rsp_timeout <= rsp_timeout_d;
      end
   end

   // Next-state and next-output logic; every registered output holds by default
   always_comb begin
      state_d       = state_q;
      paddr_d       = paddr;
      pwdata_d      = pwdata;
      pwrite_d      = pwrite;
      psel_d        = psel;
      penable_d     = penable;
      rsp_valid_d   = rsp_valid;
      rsp_rdata_d   = rsp_rdata;
      rsp_slverr_d  = rsp_slverr;
      rsp_timeout_d = rsp_timeout;
      cnt_clr       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               paddr_d   = req_addr;
               pwrite_d  = req_write;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               if (req_write == 1'(CFS_APB_WRITE)) begin
                  pwdata_d = req_wdata;
               end
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            // A ready slave wins over an expiring timeout in the same cycle
            if (pready) begin
               rsp_rdata_d   = (pwrite == 1'(CFS_APB_WRITE)) ? '0 : prdata;
               rsp_slverr_d  = pslverr;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = S_RESP;
            end else if (expired_c) begin
               rsp_rdata_d   = '0;
               rsp_slverr_d  = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cfs_apb_master.sv
// Directed bench for cfs_apb_master with a 4-cycle timeout.
module tb_cfs_apb_master;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;

   logic          pclk = 1'b0;
   logic          preset;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr, paddr;
   logic [DW-1:0] req_wdata, rsp_rdata, pwdata, prdata;
   logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
   logic          pwrite, psel, penable, pready, pslverr;

   int checks   = 0;
   int failures = 0;

   always #5 pclk = ~pclk;

   cfs_apb_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (4),
      .CNT_WIDTH      (16)
   ) dut (
      .pclk        (pclk),
      .preset      (preset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_write   (req_write),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .paddr       (paddr),
      .pwrite      (pwrite),
      .psel        (psel),
      .penable     (penable),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = w;
      req_wdata = d;
   endtask

   initial begin
      preset    = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_write = 1'b0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      tick();
      tick();

      // Reset state
      chk1("rst_psel", psel, 1'b0);
      chk1("rst_penable", penable, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_req_ready", req_ready, 1'b0);
      chk32("rst_paddr", 32'(paddr), 32'h0);
      chk32("rst_pwdata", pwdata, 32'h0);
      preset = 1'b0;
      #1;
      chk1("rst_req_ready_rel", req_ready, 1'b1);

      // Write, zero wait states
      request(16'h0010, 1'b1, 32'hDEADBEEF);
      pready = 1'b1;
      tick();
      req_valid = 1'b0;
      chk1("wr_setup_psel", psel, 1'b1);
      chk1("wr_setup_penable", penable, 1'b0);
      chk1("wr_setup_req_ready", req_ready, 1'b0);
      tick();
      chk1("wr_acc_penable", penable, 1'b1);
      chk32("wr_acc_paddr", 32'(paddr), 32'h0010);
      chk32("wr_acc_pwdata", pwdata, 32'hDEADBEEF);
      chk1("wr_acc_pwrite", pwrite, 1'b1);
      chk1("wr_acc_rsp_valid", rsp_valid, 1'b0);
      tick();
      chk1("wr_rsp_valid", rsp_valid, 1'b1);
      chk1("wr_rsp_slverr", rsp_slverr, 1'b0);
      chk1("wr_rsp_timeout", rsp_timeout, 1'b0);
      chk32("wr_rsp_rdata", rsp_rdata, 32'h0);
      chk1("wr_rsp_psel", psel, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk1("wr_done_rsp_valid", rsp_valid, 1'b0);
      chk1("wr_done_req_ready", req_ready, 1'b1);

      // Read with 3 wait states, then 5 cycles of response backpressure
      request(16'h0020, 1'b0, 32'h12345678);
      pready = 1'b0;
      prdata = 32'hFFFF_0000;
      tick();
      req_valid = 1'b0;
      chk32("rd_setup_pwdata_kept", pwdata, 32'hDEADBEEF);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk1("rd_wait_psel", psel, 1'b1);
         chk1("rd_wait_penable", penable, 1'b1);
         chk32("rd_wait_paddr", 32'(paddr), 32'h0020);
         chk1("rd_wait_pwrite", pwrite, 1'b0);
         chk1("rd_wait_rsp_valid", rsp_valid, 1'b0);
         if (i == 3) begin
            pready = 1'b1;
            prdata = 32'h0000_1234;
         end
         tick();
      end
      pready = 1'b0;
      prdata = 32'h0;
      request(16'h00FF, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk1("bp_rsp_valid", rsp_valid, 1'b1);
         chk32("bp_rsp_rdata", rsp_rdata, 32'h0000_1234);
         chk1("bp_rsp_slverr", rsp_slverr, 1'b0);
         chk1("bp_req_ready", req_ready, 1'b0);
         chk1("bp_psel", psel, 1'b0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk1("bp_idle_psel", psel, 1'b0);
      chk1("bp_idle_rsp_valid", rsp_valid, 1'b0);
      chk1("bp_idle_req_ready", req_ready, 1'b1);

      // Pending read to 0x00FF is accepted now; slave answers with an error
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'h0000_AA55;
      tick();
      req_valid = 1'b0;
      chk1("err_setup_psel", psel, 1'b1);
      chk32("err_setup_paddr", 32'(paddr), 32'h00FF);
      tick();
      tick();
      chk1("err_rsp_valid", rsp_valid, 1'b1);
      chk1("err_rsp_slverr", rsp_slverr, 1'b1);
      chk1("err_rsp_timeout", rsp_timeout, 1'b0);
      chk32("err_rsp_rdata", rsp_rdata, 32'h0000_AA55);
      pslverr   = 1'b0;
      pready    = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Timeout after exactly 4 access cycles with pready low
      request(16'h0030, 1'b0, 32'h0);
      prdata = 32'hCAFE_F00D;
      tick();
      req_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk1("to_wait_psel", psel, 1'b1);
         chk1("to_wait_rsp_valid", rsp_valid, 1'b0);
         tick();
      end
      chk1("to_psel", psel, 1'b0);
      chk1("to_penable", penable, 1'b0);
      chk1("to_rsp_valid", rsp_valid, 1'b1);
      chk1("to_rsp_slverr", rsp_slverr, 1'b1);
      chk1("to_rsp_timeout", rsp_timeout, 1'b1);
      chk32("to_rsp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // pready in the 4th access cycle wins over the timeout
      request(16'h0040, 1'b1, 32'h0000_0055);
      tick();
      req_valid = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) tick();
      chk1("edge_psel", psel, 1'b1);
      pready = 1'b1;
      tick();
      pready = 1'b0;
      chk1("edge_rsp_valid", rsp_valid, 1'b1);
      chk1("edge_rsp_timeout", rsp_timeout, 1'b0);
      chk1("edge_rsp_slverr", rsp_slverr, 1'b0);
      chk32("edge_rsp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Reset during access wait states drops the transfer
      request(16'h0050, 1'b0, 32'h0);
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk1("rsta_pre_psel", psel, 1'b1);
      preset = 1'b1;
      tick();
      chk1("rsta_psel", psel, 1'b0);
      chk1("rsta_penable", penable, 1'b0);
      chk1("rsta_rsp_valid", rsp_valid, 1'b0);
      chk32("rsta_paddr", 32'(paddr), 32'h0);
      chk1("rsta_req_ready_in_rst", req_ready, 1'b0);
      preset = 1'b0;
      #1;
      chk1("rsta_req_ready", req_ready, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk1("rsta_no_rsp", rsp_valid, 1'b0);
         chk1("rsta_idle_psel", psel, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
